// File: rtl/host_instr_unpacker_pkg.sv
// Shared SoftMC instruction field positions and constants for the host instruction unpacker.
// Also holds the long-write decode and beat-count clipping helpers.
package host_instr_unpacker_pkg;

    localparam int BEAT_W  = 128;
    localparam int CNT_W   = 3;
    localparam int ENTRY_W = BEAT_W + CNT_W;

    localparam int CAS_OFFSET     = 25;
    localparam int WE_OFFSET      = 24;
    localparam int LONG_WR_OFFSET = 21;
    localparam int BURST_OFFSET   = 20;

    localparam logic [3:0] END_ISEQ       = 4'hF;
    localparam logic [4:0] LONG_WR_DWORDS = 5'd16;

    typedef enum logic {
        CMD  = 1'b0,
        DATA = 1'b1
    } cls_state_e;

    // CAS and WE are active-low DDR command bits.
    function automatic logic is_long_wr(input logic [31:0] dw);
        return dw[31] & ~dw[CAS_OFFSET] & ~dw[WE_OFFSET] & dw[LONG_WR_OFFSET] & dw[BURST_OFFSET];
    endfunction

    function automatic logic [CNT_W-1:0] clip_cnt(input logic [CNT_W-1:0] cnt);
        return (cnt > 3'd4) ? 3'd4 : cnt;
    endfunction

endpackage

// File: rtl/host_instr_unpacker_fifo.sv
// Two-entry beat FIFO with registered occupancy and full/empty flags.
// Storage is not reset; only the pointers and occupancy are.
module beat_fifo2
    import host_instr_unpacker_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam logic [1:0] FULL_OCC = 2'(DEPTH);

    logic [WIDTH-1:0] mem [2];
    logic             wr_idx;
    logic             rd_idx;
    logic [1:0]       occ;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == FULL_OCC);
    assign empty   = (occ == 2'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) wr_idx <= ~wr_idx;
            if (do_pop)  rd_idx <= ~rd_idx;
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= wdata;
    end

endmodule

// File: rtl/host_instr_unpacker.sv
// Splits 128-bit host beats into 32-bit SoftMC dwords on a valid/ack handshake,
// skipping long-write data bursts for instruction counting and END_ISEQ detection.
module host_instr_unpacker
    import host_instr_unpacker_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic [BEAT_W-1:0]   rx_data,
    input  logic [CNT_W-1:0]    rx_dw_cnt,
    output logic                app_en,
    output logic [31:0]         app_instr,
    input  logic                app_ack,
    output logic                seq_done,
    output logic [31:0]         instr_count,
    output logic                idle
);

    logic [ENTRY_W-1:0] head;
    logic [BEAT_W-1:0]  head_data;
    logic [CNT_W-1:0]   head_cnt;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               xfer;
    logic               last;
    logic [1:0]         ptr;
    logic [31:0]        cur;

    cls_state_e state, state_nxt;
    logic [4:0] data_left, data_left_nxt;
    logic       seq_done_nxt;
    logic       count_inc;

    // Empty beats are acknowledged but never stored.
    assign rx_ready = rst_n & ~full;
    assign push     = rx_valid & rx_ready & (rx_dw_cnt != 3'd0);

    beat_fifo2 #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({clip_cnt(rx_dw_cnt), rx_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign head_data = head[BEAT_W-1:0];
    assign head_cnt  = head[ENTRY_W-1:BEAT_W];
    assign cur       = head_data[{ptr, 5'b0} +: 32];

    // Masked while empty so stale storage never shows after reset.
    assign app_en    = ~empty;
    assign app_instr = app_en ? cur : 32'd0;
    assign xfer      = app_en & app_ack;
    assign last      = ({1'b0, ptr} == (head_cnt - 3'd1));
    assign pop       = xfer & last;
    assign idle      = empty & (state == CMD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ptr <= 2'd0;
        else if (pop)  ptr <= 2'd0;
        else if (xfer) ptr <= ptr + 2'd1;
    end

    always_comb begin
        state_nxt     = state;
        data_left_nxt = data_left;
        seq_done_nxt  = 1'b0;
        count_inc     = 1'b0;
        if (xfer) begin
            case (state)
                CMD: begin
                    count_inc = 1'b1;
                    if (is_long_wr(cur)) begin
                        state_nxt     = DATA;
                        data_left_nxt = LONG_WR_DWORDS;
                    end else if (cur[31:28] == END_ISEQ) begin
                        seq_done_nxt = 1'b1;
                    end
                end
                DATA: begin
                    data_left_nxt = data_left - 5'd1;
                    if (data_left_nxt == 5'd0) state_nxt = CMD;
                end
                default: state_nxt = CMD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CMD;
            data_left   <= 5'd0;
            seq_done    <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            state       <= state_nxt;
            data_left   <= data_left_nxt;
            seq_done    <= seq_done_nxt;
            instr_count <= instr_count + 32'(count_inc);
        end
    end

endmodule

// File: tb/tb_host_instr_unpacker.sv
// Self-checking bench for host_instr_unpacker: beat table, backpressure, long-write and reset sequences.
// Expected dwords flow through a scoreboard queue; a small classifier model predicts counts and seq_done.
module tb_host_instr_unpacker;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic [127:0] rx_data = '0;
    logic [2:0]   rx_dw_cnt = '0;
    logic         app_en;
    logic [31:0]  app_instr;
    logic         app_ack = 1'b0;
    logic         seq_done;
    logic [31:0]  instr_count;
    logic         idle;

    host_instr_unpacker #(.BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_dw_cnt   (rx_dw_cnt),
        .app_en      (app_en),
        .app_instr   (app_instr),
        .app_ack     (app_ack),
        .seq_done    (seq_done),
        .instr_count (instr_count),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [2:0]   cnt;
        int           exp_n;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] sb [$];
    int          checks = 0;
    int          passes = 0;
    int          model_left = 0;
    int          model_cnt = 0;
    bit          seq_pend = 1'b0;
    int          seq_pulses = 0;
    bit          bp_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor and classifier model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            model_left = 0;
            model_cnt  = 0;
            seq_pend   = 1'b0;
            seq_pulses = 0;
        end else begin
            check("seq_done", 32'(seq_done), 32'(seq_pend));
            if (seq_done) seq_pulses++;
            seq_pend = 1'b0;
            if (app_en && app_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_dword: got %h, expected no transfer", app_instr);
                end else begin
                    e = sb.pop_front();
                    check("app_instr", app_instr, e);
                    if (model_left > 0) model_left--;
                    else begin
                        model_cnt++;
                        if (e[31] && !e[25] && !e[24] && e[21] && e[20]) model_left = 16;
                        else if (e[31:28] == 4'hF) seq_pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [127:0] d, input logic [2:0] c);
        bit acc;
        bit ok;
        int m;
        ok = 1'b0;
        rx_valid  = 1'b1;
        rx_data   = d;
        rx_dw_cnt = c;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            if (acc) ok = 1'b1;
        end
        rx_valid = 1'b0;
        if (ok) begin
            m = (c > 3'd4) ? 4 : int'(c);
            for (int k = 0; k < m; k++) sb.push_back(d[32*k +: 32]);
        end else begin
            checks++;
            $display("FAIL beat_accept: got no acceptance, expected rx_ready within 200 cycles");
        end
    endtask

    task automatic wait_drain();
        int n;
        for (n = 0; n < 300; n++) begin
            @(posedge clk);
            #2;
            if (idle && sb.size() == 0) break;
        end
        if (n == 300) begin
            checks++;
            $display("FAIL drain: got idle=%0d pending=%0d, expected idle=1 pending=0", idle, sb.size());
        end
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    initial begin
        logic [31:0] lw [18];
        logic [31:0] burst [11];
        int n;

        tbl[0] = '{pack4(32'h0A00_0001, 32'h0A00_0002, 32'h0A00_0003, 32'h0A00_0004), 3'd4, 4};
        tbl[1] = '{pack4(32'h1B00_0011, 32'h1B00_0012, 32'h1B00_0013, 32'h1B00_0014), 3'd2, 2};
        tbl[2] = '{pack4(32'h2C00_0021, 32'h2C00_0022, 32'h2C00_0023, 32'h2C00_0024), 3'd0, 0};
        tbl[3] = '{pack4(32'h3D00_0031, 32'h3D00_0032, 32'h3D00_0033, 32'h3D00_0034), 3'd7, 4};
        tbl[4] = '{pack4(32'h4E00_0041, 32'h4E00_0042, 32'h4E00_0043, 32'h4E00_0044), 3'd1, 1};
        tbl[5] = '{pack4(32'h5600_0051, 32'h5600_0052, 32'h5600_0053, 32'h5600_0054), 3'd3, 3};

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_app_en", 32'(app_en), 32'd0);
        check("rst_app_instr", app_instr, 32'd0);
        check("rst_seq_done", 32'(seq_done), 32'd0);
        check("rst_instr_count", instr_count, 32'd0);
        check("rst_idle", 32'(idle), 32'd1);

        @(negedge clk);
        rst_n   = 1'b1;
        app_ack = 1'b1;
        @(posedge clk);
        #1;

        // Table: single beats of various counts, ack held high
        for (int i = 0; i < 6; i++) begin
            send_beat(tbl[i].data, tbl[i].cnt);
            n = 0;
            while (app_en && n < 10) begin
                n++;
                @(posedge clk);
                #1;
            end
            check($sformatf("burst_len[%0d]", i), 32'(n), 32'(tbl[i].exp_n));
            check($sformatf("idle[%0d]", i), 32'(idle), 32'd1);
            check($sformatf("instr_count[%0d]", i), instr_count, 32'(model_cnt));
        end
        check("table_instr_total", instr_count, 32'd14);

        // Backpressure: three beats with app_ack low
        app_ack = 1'b0;
        fork
            begin
                send_beat(pack4(32'h6100_0001, 32'h6100_0002, 32'h6100_0003, 32'h6100_0004), 3'd4);
                send_beat(pack4(32'h6200_0001, 32'h6200_0002, 32'h6200_0003, 32'h6200_0004), 3'd4);
                send_beat(pack4(32'h6300_0001, 32'h6300_0002, 32'h6300_0003, 32'h6300_0004), 3'd4);
                bp_done = 1'b1;
            end
        join_none
        repeat (6) @(posedge clk);
        #2;
        check("bp_rx_ready_full", 32'(rx_ready), 32'd0);
        check("bp_app_en", 32'(app_en), 32'd1);
        check("bp_hold_dword0", app_instr, 32'h6100_0001);
        app_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_rx_ready_low[%0d]", k), 32'(rx_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        check("bp_rx_ready_after_pop", 32'(rx_ready), 32'd1);
        n = 0;
        while (!bp_done && n < 100) begin
            n++;
            @(posedge clk);
        end
        check("bp_sender_done", 32'(bp_done), 32'd1);
        wait_drain();
        check("bp_instr_count", instr_count, 32'd26);

        // Long write: command, 16 data dwords (one mimics END_ISEQ), real END_ISEQ
        lw[0] = 32'h8030_0000;
        for (int k = 1; k <= 16; k++) lw[k] = 32'h7700_0000 + 32'(k);
        lw[6]  = 32'hF000_0000;
        lw[10] = 32'h8030_0000;
        lw[17] = 32'hF000_0000;
        n = seq_pulses;
        for (int b = 0; b < 4; b++)
            send_beat(pack4(lw[4*b], lw[4*b+1], lw[4*b+2], lw[4*b+3]), 3'd4);
        send_beat(pack4(lw[16], lw[17], 32'h0, 32'h0), 3'd2);
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        check("lw_instr_count", instr_count, 32'd28);
        check("lw_seq_pulses", 32'(seq_pulses - n), 32'd1);

        // Reset in the middle of a long-write burst
        burst[0] = 32'h8030_0000;
        for (int k = 1; k < 11; k++) burst[k] = 32'h3300_0000 + 32'(k);
        app_ack = 1'b0;
        send_beat(pack4(burst[0], burst[1], burst[2], burst[3]), 3'd4);
        send_beat(pack4(burst[4], burst[5], burst[6], burst[7]), 3'd4);
        app_ack = 1'b1;
        send_beat(pack4(burst[8], burst[9], burst[10], 32'hF000_0000), 3'd4);
        for (n = 0; n < 50; n++) begin
            if (model_left == 8) break;
            @(posedge clk);
            #1;
        end
        check("rm_reached_dword8", 32'(model_left), 32'd8);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("rm_rx_ready", 32'(rx_ready), 32'd0);
        check("rm_app_en", 32'(app_en), 32'd0);
        check("rm_app_instr", app_instr, 32'd0);
        check("rm_seq_done", 32'(seq_done), 32'd0);
        check("rm_instr_count", instr_count, 32'd0);
        check("rm_idle", 32'(idle), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rm_no_glitch", 32'(app_en), 32'd0);
        end
        send_beat(pack4(32'hF000_0000, 32'h0, 32'h0, 32'h0), 3'd1);
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        check("rm_post_instr_count", instr_count, 32'd1);
        check("rm_post_seq_pulses", 32'(seq_pulses), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "timeout");
    end

endmodule
